adc_sample_sequencer: RTL and testbench

Paces and sequences conversions of the voltmeter's external ADC. An enable-gated prescaler produces a sample tick every SAMPLE_DIV clk_i cycles. On each tick the block pulses a conversion start, then waits for done with a timeout. It averages 2^AVG_LOG2 results and publishes the mean with a one-cycle valid strobe to the display/formatting logic.

---
 rtl/voltmeter_pkg.sv | 19 +
 rtl/tick_prescaler.sv | 31 +++
 rtl/adc_sample_sequencer.sv | 130 +++++++++++++
 tb/tb_adc_sample_sequencer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/voltmeter_pkg.sv
// Shared types and default constants for the voltmeter front end.
// The sample rate is 500 Hz derived from the 2.08 MHz system clock.
package voltmeter_pkg;

   localparam int unsigned CLK_FREQ_HZ    = 2_080_000;
   localparam int unsigned SAMPLE_DIV_DEF = 4160;
   localparam int unsigned AVG_LOG2_DEF   = 3;
   localparam int unsigned ADC_W_DEF      = 10;
   localparam int unsigned TIMEOUT_DEF    = 255;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_TICK = 3'd1,
      START     = 3'd2,
      WAIT_DONE = 3'd3,
      PUBLISH   = 3'd4
   } seq_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Enable-gated modulo-DIV counter producing a one-cycle tick on the last count.
// Dropping enable clears the count, so the first tick arrives DIV cycles after enable rises.
module tick_prescaler #(
   parameter int unsigned DIV = 4160
) (
   input  logic clk_i,
   input  logic reset_n,
   input  logic enable_i,
   output logic tick_o
);

   localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (!enable_i) begin
         count <= '0;
      end else if (count == LAST) begin
         count <= '0;
      end else begin
         count <= count + CW'(1);
      end
   end

   assign tick_o = enable_i && (count == LAST);

endmodule

// File: rtl/adc_sample_sequencer.sv
// Paces external ADC conversions, guards each with a timeout and publishes
// the mean of 2^AVG_LOG2 accepted results with a one-cycle valid strobe.
module adc_sample_sequencer
   import voltmeter_pkg::*;
#(
   parameter int unsigned SAMPLE_DIV = SAMPLE_DIV_DEF,
   parameter int unsigned AVG_LOG2   = AVG_LOG2_DEF,
   parameter int unsigned ADC_W      = ADC_W_DEF,
   parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
   input  logic             clk_i,
   input  logic             reset_n,
   input  logic             enable_i,
   output logic             adc_start_o,
   input  logic             adc_done_i,
   input  logic [ADC_W-1:0] adc_data_i,
   output logic [ADC_W-1:0] avg_o,
   output logic             avg_valid_o,
   output logic             timeout_o,
   output logic             busy_o,
   output logic [2:0]       state_o
);

   localparam int unsigned ACC_W = ADC_W + AVG_LOG2;
   localparam int unsigned CNT_W = AVG_LOG2 + 1;
   localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] N_SAMPLES = CNT_W'(1 << AVG_LOG2);
   localparam logic [TO_W-1:0]  TO_LIMIT  = TO_W'(TIMEOUT);

   seq_state_e       state;
   logic             tick;
   logic [ACC_W-1:0] acc;
   logic [CNT_W-1:0] cnt;
   logic [TO_W-1:0]  to_cnt;
   logic [ACC_W-1:0] acc_sum;
   logic [CNT_W-1:0] cnt_inc;
   logic [TO_W-1:0]  to_inc;

   tick_prescaler #(
      .DIV (SAMPLE_DIV)
   ) u_prescaler (
      .clk_i    (clk_i),
      .reset_n  (reset_n),
      .enable_i (enable_i),
      .tick_o   (tick)
   );

   assign acc_sum = acc + ACC_W'(adc_data_i);
   assign cnt_inc = cnt + CNT_W'(1);
   assign to_inc  = to_cnt + TO_W'(1);
   assign state_o = state;

   // ADC handshake: adc_start_o is a single-cycle request issued from START;
   // adc_done_i is a single-cycle strobe qualifying adc_data_i and is only
   // honoured in WAIT_DONE. There is no back-pressure in either direction.
   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         state       <= IDLE;
         acc         <= '0;
         cnt         <= '0;
         to_cnt      <= '0;
         adc_start_o <= 1'b0;
         avg_o       <= '0;
         avg_valid_o <= 1'b0;
         timeout_o   <= 1'b0;
         busy_o      <= 1'b0;
      end else begin
         adc_start_o <= 1'b0;
         avg_valid_o <= 1'b0;
         if (!enable_i) begin
            // Abort: drop any partial average, keep the last published result.
            state  <= IDLE;
            busy_o <= 1'b0;
            acc    <= '0;
            cnt    <= '0;
            to_cnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  state <= WAIT_TICK;
               end
               WAIT_TICK: begin
                  if (tick) begin
                     state       <= START;
                     adc_start_o <= 1'b1;
                     busy_o      <= 1'b1;
                  end
               end
               START: begin
                  to_cnt <= '0;
                  state  <= WAIT_DONE;
               end
               WAIT_DONE: begin
                  to_cnt <= to_inc;
                  // A done arriving on the expiry cycle takes priority over the timeout.
                  if (adc_done_i) begin
                     busy_o <= 1'b0;
                     if (cnt_inc == N_SAMPLES) begin
                        avg_o       <= ADC_W'(acc_sum >> AVG_LOG2);
                        avg_valid_o <= 1'b1;
                        timeout_o   <= 1'b0;
                        acc         <= '0;
                        cnt         <= '0;
                        state       <= PUBLISH;
                     end else begin
                        acc   <= acc_sum;
                        cnt   <= cnt_inc;
                        state <= WAIT_TICK;
                     end
                  end else if (to_inc == TO_LIMIT) begin
                     timeout_o <= 1'b1;
                     busy_o    <= 1'b0;
                     acc       <= '0;
                     cnt       <= '0;
                     state     <= WAIT_TICK;
                  end
               end
               PUBLISH: begin
                  state <= WAIT_TICK;
               end
               default: begin
                  state  <= IDLE;
                  busy_o <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Directed bench for adc_sample_sequencer: a conversion table plus hand-written
// sequences for reset, abort and stray done pulses.
module tb_adc_sample_sequencer;
   import voltmeter_pkg::*;

   localparam int unsigned SAMPLE_DIV = 20;
   localparam int unsigned AVG_LOG2   = 2;
   localparam int unsigned ADC_W      = 10;
   localparam int unsigned TIMEOUT    = 8;
   localparam int          NVEC       = 19;

   typedef struct {
      int               lat;
      logic [ADC_W-1:0] data;
      logic             exp_valid;
      logic [ADC_W-1:0] exp_avg;
      logic             exp_to;
   } vec_t;

   logic             clk_i      = 1'b0;
   logic             reset_n    = 1'b1;
   logic             enable_i   = 1'b0;
   logic             adc_done_i = 1'b0;
   logic [ADC_W-1:0] adc_data_i = '0;
   logic             adc_start_o;
   logic [ADC_W-1:0] avg_o;
   logic             avg_valid_o;
   logic             timeout_o;
   logic             busy_o;
   logic [2:0]       state_o;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int last_start_cyc = -1;
   int enable_cyc = 0;
   logic [ADC_W-1:0] exp_q[$];
   vec_t vecs [NVEC];

   adc_sample_sequencer #(
      .SAMPLE_DIV (SAMPLE_DIV),
      .AVG_LOG2   (AVG_LOG2),
      .ADC_W      (ADC_W),
      .TIMEOUT    (TIMEOUT)
   ) dut (
      .clk_i       (clk_i),
      .reset_n     (reset_n),
      .enable_i    (enable_i),
      .adc_start_o (adc_start_o),
      .adc_done_i  (adc_done_i),
      .adc_data_i  (adc_data_i),
      .avg_o       (avg_o),
      .avg_valid_o (avg_valid_o),
      .timeout_o   (timeout_o),
      .busy_o      (busy_o),
      .state_o     (state_o)
   );

   // Clock and cycle counter
   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Waits for the next start, answers after lat WAIT_DONE cycles (0 = silent),
   // then checks the outcome on the cycle after the deciding edge.
   task automatic run_conv(input int lat, input logic [ADC_W-1:0] data, input logic exp_valid,
                           input logic [ADC_W-1:0] exp_avg, input logic exp_to);
      int waited = 0;
      int stray = 0;
      int expect_cyc;
      do begin
         @(negedge clk_i);
         waited++;
         if (adc_start_o !== 1'b1 && (avg_valid_o !== 1'b0 || busy_o !== 1'b0)) stray++;
      end while (adc_start_o !== 1'b1 && waited < 3 * SAMPLE_DIV);
      check("start_seen", adc_start_o, 1);
      check("quiet_before_start", stray, 0);
      expect_cyc = (last_start_cyc < 0) ? enable_cyc + SAMPLE_DIV : last_start_cyc + SAMPLE_DIV;
      check("start_time", cyc, expect_cyc);
      last_start_cyc = cyc;
      check("busy_in_start", busy_o, 1);
      for (int k = 1; k <= TIMEOUT; k++) begin
         @(negedge clk_i);
         if (k == 1) check("start_width", adc_start_o, 0);
         check("busy_in_wait", busy_o, 1);
         if (k == lat) begin
            adc_done_i = 1'b1;
            adc_data_i = data;
         end
         if (k == lat || k == TIMEOUT) break;
      end
      @(negedge clk_i);
      adc_done_i = 1'b0;
      adc_data_i = ADC_W'($urandom_range(0, 1023));
      if (exp_valid) exp_q.push_back(exp_avg);
      check("avg_valid", avg_valid_o, exp_valid);
      check("timeout", timeout_o, exp_to);
      check("busy_after", busy_o, 0);
      if (avg_valid_o === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_publish", 1, 0);
         end else begin
            check("published_avg", avg_o, exp_q.pop_front());
         end
      end else begin
         check("avg_hold", avg_o, exp_avg);
      end
   endtask

   task automatic stray_done(input logic [ADC_W-1:0] data, input logic [ADC_W-1:0] exp_avg);
      @(negedge clk_i);
      adc_done_i = 1'b1;
      adc_data_i = data;
      @(negedge clk_i);
      adc_done_i = 1'b0;
      check("stray_state", state_o, WAIT_TICK);
      check("stray_valid", avg_valid_o, 0);
      check("stray_avg", avg_o, exp_avg);
      check("stray_busy", busy_o, 0);
   endtask

   initial begin
      int starts;
      int nonzero;
      int waited;

      vecs[0]  = '{3, 10'd100,  1'b0, 10'd0,    1'b0};
      vecs[1]  = '{3, 10'd101,  1'b0, 10'd0,    1'b0};
      vecs[2]  = '{3, 10'd102,  1'b0, 10'd0,    1'b0};
      vecs[3]  = '{3, 10'd103,  1'b1, 10'd101,  1'b0};
      vecs[4]  = '{3, 10'd1023, 1'b0, 10'd101,  1'b0};
      vecs[5]  = '{2, 10'd1023, 1'b0, 10'd101,  1'b0};
      vecs[6]  = '{1, 10'd1023, 1'b0, 10'd101,  1'b0};
      vecs[7]  = '{3, 10'd1023, 1'b1, 10'd1023, 1'b0};
      vecs[8]  = '{3, 10'd200,  1'b0, 10'd1023, 1'b0};
      vecs[9]  = '{0, 10'd0,    1'b0, 10'd1023, 1'b1};
      vecs[10] = '{3, 10'd200,  1'b0, 10'd1023, 1'b1};
      vecs[11] = '{3, 10'd200,  1'b0, 10'd1023, 1'b1};
      vecs[12] = '{3, 10'd200,  1'b0, 10'd1023, 1'b1};
      vecs[13] = '{3, 10'd200,  1'b1, 10'd200,  1'b0};
      vecs[14] = '{3, 10'd51,   1'b0, 10'd200,  1'b0};
      vecs[15] = '{8, 10'd60,   1'b0, 10'd200,  1'b0};
      vecs[16] = '{3, 10'd70,   1'b0, 10'd200,  1'b0};
      vecs[17] = '{8, 10'd80,   1'b1, 10'd65,   1'b0};
      vecs[18] = '{0, 10'd0,    1'b0, 10'd65,   1'b1};

      // Reset and idle with enable low
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk_i);
      check("rst_start", adc_start_o, 0);
      check("rst_avg", avg_o, 0);
      check("rst_valid", avg_valid_o, 0);
      check("rst_timeout", timeout_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_state", state_o, IDLE);
      reset_n = 1'b1;
      starts = 0;
      nonzero = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk_i);
         if (adc_start_o !== 1'b0) starts++;
         if (avg_o !== '0 || avg_valid_o !== 1'b0 || timeout_o !== 1'b0 || busy_o !== 1'b0) nonzero++;
      end
      check("disabled_starts", starts, 0);
      check("disabled_outputs", nonzero, 0);

      // Table of conversions under continuous enable
      enable_i = 1'b1;
      enable_cyc = cyc;
      last_start_cyc = -1;
      for (int v = 0; v < NVEC; v++) begin
         run_conv(vecs[v].lat, vecs[v].data, vecs[v].exp_valid, vecs[v].exp_avg, vecs[v].exp_to);
      end

      // Asynchronous reset in the middle of WAIT_DONE
      waited = 0;
      do begin
         @(negedge clk_i);
         waited++;
      end while (adc_start_o !== 1'b1 && waited < 3 * SAMPLE_DIV);
      check("arst_start_seen", adc_start_o, 1);
      @(negedge clk_i);
      @(negedge clk_i);
      check("arst_pre_busy", busy_o, 1);
      check("arst_pre_timeout", timeout_o, 1);
      #2 reset_n = 1'b0;
      #1;
      check("arst_avg", avg_o, 0);
      check("arst_timeout", timeout_o, 0);
      check("arst_busy", busy_o, 0);
      check("arst_start", adc_start_o, 0);
      check("arst_state", state_o, IDLE);
      enable_i = 1'b0;
      @(negedge clk_i);
      reset_n = 1'b1;
      repeat (2) @(negedge clk_i);

      // Abort during WAIT_DONE after two samples, late done must be ignored
      enable_i = 1'b1;
      enable_cyc = cyc;
      last_start_cyc = -1;
      run_conv(3, 10'd900, 1'b0, 10'd0, 1'b0);
      run_conv(3, 10'd900, 1'b0, 10'd0, 1'b0);
      waited = 0;
      do begin
         @(negedge clk_i);
         waited++;
      end while (adc_start_o !== 1'b1 && waited < 3 * SAMPLE_DIV);
      check("abort_start_seen", adc_start_o, 1);
      @(negedge clk_i);
      @(negedge clk_i);
      enable_i = 1'b0;
      @(negedge clk_i);
      check("abort_state", state_o, IDLE);
      check("abort_busy", busy_o, 0);
      adc_done_i = 1'b1;
      adc_data_i = 10'd900;
      @(negedge clk_i);
      adc_done_i = 1'b0;
      check("late_done_valid", avg_valid_o, 0);
      check("late_done_avg", avg_o, 0);
      check("late_done_timeout", timeout_o, 0);
      starts = 0;
      for (int i = 0; i < 10; i++) begin
         adc_done_i = (i % 3 == 0);
         @(negedge clk_i);
         if (adc_start_o !== 1'b0 || avg_valid_o !== 1'b0) starts++;
      end
      adc_done_i = 1'b0;
      check("disabled_done_quiet", starts, 0);

      // Re-enable: prescaler restarts, average must not include the 900s
      enable_i = 1'b1;
      enable_cyc = cyc;
      last_start_cyc = -1;
      for (int i = 0; i < 4; i++) begin
         run_conv(3, 10'd40, (i == 3), (i == 3) ? 10'd40 : 10'd0, 1'b0);
         if (i < 3) stray_done(10'd900, 10'd0);
      end
      stray_done(10'd1000, 10'd40);

      check("exp_q_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
